// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: picks decode operand bypass sources and
// sequences load-use and branch stalls, counting every fetch-stall cycle.
module hazard_ctrl_unit #(
    parameter int REG_W          = 3,
    parameter int LOAD_PENALTY   = 1,
    parameter int BRANCH_PENALTY = 1,
    parameter int ZERO_REG       = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_a_d,
    input  logic [REG_W-1:0] rs_b_d,
    input  logic             use_a_d,
    input  logic             use_b_d,
    input  logic             branch_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             regwrite_e,
    input  logic             load_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic             regwrite_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             regwrite_w,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        BR_WAIT   = 2'b10
    } state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [CNT_W-1:0] stall_q;

    logic a_e, a_m, a_w, b_e, b_m, b_w;
    logic lu_haz;

    function automatic logic src_match(input logic use_x, input logic [REG_W-1:0] rs,
                                       input logic wr, input logic [REG_W-1:0] rd);
        return use_x && wr && (rs == rd) && ((ZERO_REG == 0) || (rs != '0));
    endfunction

    // Newest producer wins; a load in E has no ALU result to bypass yet.
    function automatic logic [1:0] fwd_sel(input logic me, input logic mm,
                                           input logic mw, input logic ld);
        if (me && !ld)
            return 2'b11;
        else if (mm)
            return 2'b01;
        else if (mw)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign a_e = src_match(use_a_d, rs_a_d, regwrite_e, rd_e);
    assign a_m = src_match(use_a_d, rs_a_d, regwrite_m, rd_m);
    assign a_w = src_match(use_a_d, rs_a_d, regwrite_w, rd_w);
    assign b_e = src_match(use_b_d, rs_b_d, regwrite_e, rd_e);
    assign b_m = src_match(use_b_d, rs_b_d, regwrite_m, rd_m);
    assign b_w = src_match(use_b_d, rs_b_d, regwrite_w, rd_w);

    assign lu_haz = load_e && (a_e || b_e);

    assign fwd_a     = reset ? 2'b00 : fwd_sel(a_e, a_m, a_w, load_e);
    assign fwd_b     = reset ? 2'b00 : fwd_sel(b_e, b_m, b_w, load_e);
    assign busy      = !reset && (state != IDLE);
    assign stall_cnt = reset ? '0 : stall_q;

    // The first stall cycle must be raised in the same cycle the hazard is seen,
    // so pipeline controls are decoded from the state and the live hazard terms.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (lu_haz) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (branch_d) begin
                        stall_f = 1'b1;
                        flush_d = 1'b1;
                    end
                end
                LOAD_WAIT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                BR_WAIT: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The IDLE cycle that detects a hazard is its first bubble, so the wait
    // states only cover the remaining PENALTY-1 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            stall_q <= '0;
        end else begin
            if (stall_f && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            case (state)
                IDLE: begin
                    if (lu_haz) begin
                        if (LOAD_PENALTY > 1) begin
                            cnt   <= 3'(LOAD_PENALTY - 1);
                            state <= LOAD_WAIT;
                        end
                    end else if (branch_d) begin
                        if (BRANCH_PENALTY > 1) begin
                            cnt   <= 3'(BRANCH_PENALTY - 1);
                            state <= BR_WAIT;
                        end
                    end
                end
                LOAD_WAIT, BR_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule
